// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, drives the instruction-memory word
// address and hands fetched {pc, instr} pairs to decode through a 2-entry buffer.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    output logic        fetch_err,
    output logic [31:0] err_pc
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 2;

    // Architectural state: PC, buffer (entry 0 is the head), sticky error.
    logic [W-1:0]  r_pc;
    logic [CW-1:0] r_count;
    logic [W-1:0]  r_pc0, r_in0, r_pc1, r_in1;
    logic          r_fetch_err;
    logic [W-1:0]  r_err_pc;

    logic [W-1:0]  w_word;
    logic          w_legal;
    logic          w_redirect;
    logic          w_can_fetch;
    logic          w_pop;
    logic          w_push;
    logic          w_trap;
    logic [CW-1:0] w_fill;

    logic [W-1:0]  w_pc_n;
    logic [CW-1:0] w_count_n;
    logic [W-1:0]  w_pc0_n, w_in0_n, w_pc1_n, w_in1_n;
    logic          w_err_n;
    logic [W-1:0]  w_err_pc_n;

    // Address, legality and handshake qualifiers; a redirect under error is ignored.
    always_comb begin
        w_word      = {2'b00, r_pc[W-1:2]};
        w_legal     = (r_pc[1:0] == 2'b00) && (w_word < W'(IMEM_WORDS));
        w_redirect  = redirect_valid && !r_fetch_err;
        w_can_fetch = fetch_en && !redirect_valid && !r_fetch_err;
        w_pop       = (r_count != '0) && id_ready && !w_redirect;
        w_push      = w_can_fetch && w_legal && ((r_count != CW'(2)) || w_pop);
        w_trap      = w_can_fetch && !w_legal;
        w_fill      = r_count - CW'(w_pop);
    end

    // Next-state: redirect flushes and reloads; otherwise pop shifts, push fills the first free slot.
    always_comb begin
        w_pc_n     = r_pc;
        w_count_n  = r_count;
        w_pc0_n    = r_pc0;
        w_in0_n    = r_in0;
        w_pc1_n    = r_pc1;
        w_in1_n    = r_in1;
        w_err_n    = r_fetch_err;
        w_err_pc_n = r_err_pc;
        if (w_redirect) begin
            w_count_n = '0;
            w_pc_n    = redirect_pc;
        end else begin
            if (w_trap) begin
                w_err_n    = 1'b1;
                w_err_pc_n = r_pc;
            end
            if (w_pop) begin
                w_pc0_n = r_pc1;
                w_in0_n = r_in1;
            end
            if (w_push) begin
                w_pc_n = r_pc + W'(4);
                if (w_fill == '0) begin
                    w_pc0_n = r_pc;
                    w_in0_n = imem_rdata;
                end else begin
                    w_pc1_n = r_pc;
                    w_in1_n = imem_rdata;
                end
            end
            w_count_n = w_fill + CW'(w_push);
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc        <= RESET_PC;
            r_count     <= '0;
            r_pc0       <= '0;
            r_in0       <= '0;
            r_pc1       <= '0;
            r_in1       <= '0;
            r_fetch_err <= 1'b0;
            r_err_pc    <= '0;
        end else begin
            r_pc        <= w_pc_n;
            r_count     <= w_count_n;
            r_pc0       <= w_pc0_n;
            r_in0       <= w_in0_n;
            r_pc1       <= w_pc1_n;
            r_in1       <= w_in1_n;
            r_fetch_err <= w_err_n;
            r_err_pc    <= w_err_pc_n;
        end
    end

    // Outputs decode directly from registers; an empty buffer reads as zero.
    assign imem_addr = w_word;
    assign if_valid  = (r_count != '0);
    assign if_pc     = if_valid ? r_pc0 : '0;
    assign if_instr  = if_valid ? r_in0 : '0;
    assign fetch_err = r_fetch_err;
    assign err_pc    = r_err_pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: cycle tables for the main DUT, delivered-instruction
// scoreboard, and a small-memory instance for the out-of-range trap.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_ready = 1'b0;
    logic [31:0] imem_addr, imem_rdata, if_instr, if_pc, err_pc;
    logic        if_valid, fetch_err;

    logic        s_fe = 1'b1;
    logic        s_rdy = 1'b1;
    logic        s_rv = 1'b0;
    logic [31:0] s_rpc = 32'h0;
    logic [31:0] s_addr, s_rdata, s_instr, s_pc, s_epc;
    logic        s_valid, s_err;

    always #5 clk = ~clk;

    // Memory word k holds 0x1000_0000 + k.
    assign imem_rdata = 32'h1000_0000 + imem_addr;
    assign s_rdata    = 32'h1000_0000 + s_addr;

    fetch_sequencer #(.RESET_PC(32'h0), .IMEM_WORDS(256)) dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
        .fetch_err(fetch_err), .err_pc(err_pc)
    );

    fetch_sequencer #(.RESET_PC(32'h0), .IMEM_WORDS(4)) dut_s (
        .clk(clk), .reset(reset), .fetch_en(s_fe), .imem_addr(s_addr),
        .imem_rdata(s_rdata), .redirect_valid(s_rv), .redirect_pc(s_rpc),
        .if_valid(s_valid), .if_instr(s_instr), .if_pc(s_pc), .id_ready(s_rdy),
        .fetch_err(s_err), .err_pc(s_epc)
    );

    typedef struct {
        logic        fe;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_addr;
        logic        e_err;
        logic [31:0] e_epc;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] sb_q[$];
    logic [31:0] sq[$];
    int          n_pass = 0;
    int          n_total = 0;

    function automatic vec_t mk(input logic fe, input logic rdy, input logic rv,
                                input logic [31:0] rpc, input logic ev, input logic [31:0] epc_if,
                                input logic [31:0] eaddr, input logic eerr, input logic [31:0] eepc);
        vec_t v;
        v.fe = fe; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.e_valid = ev; v.e_pc = epc_if; v.e_addr = eaddr; v.e_err = eerr; v.e_epc = eepc;
        return v;
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return 32'h1000_0000 + (pc >> 2);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %h exp %h", name, got, exp);
    endtask

    // Compare a delivered head against the oldest expected PC.
    task automatic sb_take(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                           inout logic [31:0] q[$]);
        logic [31:0] e;
        if (q.size() == 0) begin
            n_total++;
            $display("FAIL %s_extra unexpected delivery pc %h", tag, pc);
        end else begin
            e = q.pop_front();
            check({tag, "_pc"}, pc, e);
            check({tag, "_instr"}, instr, word_of(e));
        end
    endtask

    // Drive one row at the negedge, record any handshake, then check state after the edge.
    task automatic step(input vec_t v, input string tag, input int row);
        fetch_en = v.fe; id_ready = v.rdy; redirect_valid = v.rv; redirect_pc = v.rpc;
        if (if_valid && id_ready && !v.rv) sb_take($sformatf("%s%0d_sb", tag, row), if_pc, if_instr, sb_q);
        @(posedge clk);
        @(negedge clk);
        check($sformatf("%s%0d_valid", tag, row), 32'(if_valid), 32'(v.e_valid));
        check($sformatf("%s%0d_pc", tag, row), if_pc, v.e_pc);
        check($sformatf("%s%0d_instr", tag, row), if_instr, v.e_valid ? word_of(v.e_pc) : 32'h0);
        check($sformatf("%s%0d_addr", tag, row), imem_addr, v.e_addr);
        check($sformatf("%s%0d_err", tag, row), 32'(fetch_err), 32'(v.e_err));
        check($sformatf("%s%0d_errpc", tag, row), err_pc, v.e_epc);
    endtask

    task automatic run_tbl(input string tag);
        for (int i = 0; i < tbl.size(); i++) step(tbl[i], tag, i + 1);
        check({tag, "_sb_left"}, 32'(sb_q.size()), 32'h0);
        tbl.delete();
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1; fetch_en = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        @(negedge clk);
        @(negedge clk);
        check({tag, "_rst_valid"}, 32'(if_valid), 32'h0);
        check({tag, "_rst_pc"}, if_pc, 32'h0);
        check({tag, "_rst_instr"}, if_instr, 32'h0);
        check({tag, "_rst_addr"}, imem_addr, 32'h0);
        check({tag, "_rst_err"}, 32'(fetch_err), 32'h0);
        check({tag, "_rst_errpc"}, err_pc, 32'h0);
        sb_q.delete();
        reset = 1'b0;
    endtask

    initial begin
        // Streaming, redirect to 0x1C, fetch_en pause.
        do_reset("A");
        sb_q = '{32'h0, 32'h4, 32'h1C, 32'h20, 32'h24};
        tbl.push_back(mk(1, 1, 0, 32'h0,  1, 32'h0,  32'h1, 0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 32'h0,  1, 32'h4,  32'h2, 0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 32'h0,  1, 32'h8,  32'h3, 0, 32'h0));
        tbl.push_back(mk(1, 1, 1, 32'h1C, 0, 32'h0,  32'h7, 0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 32'h0,  1, 32'h1C, 32'h8, 0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 32'h0,  1, 32'h20, 32'h9, 0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 32'h0,  0, 32'h0,  32'h9, 0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 32'h0,  1, 32'h24, 32'hA, 0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 32'h0,  1, 32'h28, 32'hB, 0, 32'h0));
        run_tbl("A");

        // Backpressure from reset, then release.
        do_reset("B");
        sb_q = '{32'h0, 32'h4, 32'h8};
        tbl.push_back(mk(1, 0, 0, 32'h0, 1, 32'h0, 32'h1, 0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h0, 1, 32'h0, 32'h2, 0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h0, 1, 32'h0, 32'h2, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0, 1, 32'h0, 32'h2, 0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 32'h0, 1, 32'h4, 32'h3, 0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 32'h0, 1, 32'h8, 32'h4, 0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 32'h0, 1, 32'hC, 32'h5, 0, 32'h0));
        run_tbl("B");

        // Misaligned redirect traps; later redirect is ignored.
        do_reset("C");
        tbl.push_back(mk(1, 1, 0, 32'h0, 1, 32'h0, 32'h1, 0, 32'h0));
        tbl.push_back(mk(1, 1, 1, 32'h6, 0, 32'h0, 32'h1, 0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 32'h0, 0, 32'h0, 32'h1, 1, 32'h6));
        tbl.push_back(mk(1, 1, 1, 32'h0, 0, 32'h0, 32'h1, 1, 32'h6));
        tbl.push_back(mk(1, 1, 0, 32'h0, 0, 32'h0, 32'h1, 1, 32'h6));
        run_tbl("C");

        // Out-of-range on the 4-word instance; buffered entries drain after the trap.
        s_fe = 1'b1; s_rdy = 1'b0;
        do_reset("D");
        sq = '{32'h0, 32'h4, 32'h8, 32'hC};
        for (int c = 0; c < 9; c++) begin
            s_rdy = (c >= 2);
            if (s_valid && s_rdy) sb_take($sformatf("D%0d_sb", c), s_pc, s_instr, sq);
            @(posedge clk);
            @(negedge clk);
            if (c == 4) begin
                check("D_err_while_draining", 32'(s_err), 32'h1);
                check("D_valid_while_draining", 32'(s_valid), 32'h1);
            end
        end
        check("D_err", 32'(s_err), 32'h1);
        check("D_errpc", s_epc, 32'h10);
        check("D_addr", s_addr, 32'h4);
        check("D_valid", 32'(s_valid), 32'h0);
        check("D_sb_left", 32'(sq.size()), 32'h0);

        // Asynchronous reset with a full buffer, then restart at RESET_PC.
        do_reset("E");
        tbl.push_back(mk(1, 0, 0, 32'h0, 1, 32'h0, 32'h1, 0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h0, 1, 32'h0, 32'h2, 0, 32'h0));
        run_tbl("E");
        #2 reset = 1'b1;
        #1;
        check("E_async_valid", 32'(if_valid), 32'h0);
        check("E_async_pc", if_pc, 32'h0);
        check("E_async_addr", imem_addr, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        sb_q = '{32'h0, 32'h4};
        tbl.push_back(mk(1, 1, 0, 32'h0, 1, 32'h0, 32'h1, 0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 32'h0, 1, 32'h4, 32'h2, 0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 32'h0, 1, 32'h8, 32'h3, 0, 32'h0));
        run_tbl("F");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
